// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES round controller.
// Contents: FSM state enum, round counts per key size, round index width, block width.
package aes_pkg;
  localparam int AES_NR128 = 10;
  localparam int AES_NR192 = 12;
  localparam int AES_NR256 = 14;
  localparam int ROUND_W = 4;
  localparam int AES_BLOCK_W = 128;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_REQ,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;
endpackage

// File: rtl/aes_rnd_watchdog.sv
// aes_rnd_watchdog: cycle counter that flags expiry after LIMIT enabled cycles.
// Ports: clk, reset (sync, active-high), clr_i (restart count), en_i (count this cycle),
//        expire_o (high in the LIMIT-th consecutive enabled cycle).
module aes_rnd_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expire_o = en_i && cnt_q == CW'(LIMIT - 1);
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer (key fetch, round issue, result capture).
// Ports: start_valid/start_ready/data_in accept a plaintext block; key_req/key_idx/
//        key_valid_in/round_key fetch round keys; rd_* issue a round and rd_valid_in/
//        rd_data_in return its result; out_valid/out_ready/data_out deliver the ciphertext;
//        abort cancels a block; err pulses on abort or watchdog expiry.
// Option: define AES_RND_CTRL_TIMEOUT_EN to enable the KEY_REQ/WAIT watchdog.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_BLOCK_W,
  parameter int NR = AES_NR128,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               abort,
  output logic               key_req,
  output logic [ROUND_W-1:0] key_idx,
  input  logic               key_valid_in,
  input  logic [DATA_W-1:0]  round_key,
  output logic               rd_valid,
  output logic [ROUND_W-1:0] rd_round,
  output logic               rd_first,
  output logic               rd_final,
  output logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  rd_key,
  input  logic               rd_valid_in,
  input  logic [DATA_W-1:0]  rd_data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  data_out,
  output logic               err
);
  state_e fsm_q, fsm_d;
  logic [DATA_W-1:0] state_q, state_d, key_q, key_d, data_out_q, data_out_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic out_valid_q, out_valid_d, err_q, err_d;
  logic last, accept, rd_done, kill, tmo;

  assign last = round_q == ROUND_W'(NR);
  assign accept = fsm_q == ST_IDLE && start_valid;
  assign rd_done = fsm_q == ST_WAIT && rd_valid_in;
  assign kill = (abort || tmo) && fsm_q != ST_IDLE;

`ifdef AES_RND_CTRL_TIMEOUT_EN
  aes_rnd_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (fsm_d != fsm_q),
    .en_i     (fsm_q == ST_KEY_REQ || fsm_q == ST_WAIT),
    .expire_o (tmo)
  );
`else
  // Never true for a legal limit; keeps TIMEOUT_CYC referenced when the watchdog is absent.
  assign tmo = TIMEOUT_CYC < 0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      round_q     <= round_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      ST_IDLE:    if (start_valid) fsm_d = ST_KEY_REQ;
      ST_KEY_REQ: if (key_valid_in) fsm_d = ST_ISSUE;
      ST_ISSUE:   fsm_d = ST_WAIT;
      ST_WAIT:    if (rd_valid_in) fsm_d = last ? ST_DONE : ST_KEY_REQ;
      ST_DONE:    if (out_ready) fsm_d = ST_IDLE;
      default:    fsm_d = ST_IDLE;
    endcase
    if (kill) fsm_d = ST_IDLE;
    state_d     = accept ? data_in : rd_done ? rd_data_in : state_q;
    key_d       = fsm_q == ST_KEY_REQ && key_valid_in ? round_key : key_q;
    round_d     = accept ? '0 : rd_done && !last ? round_q + ROUND_W'(1) : round_q;
    data_out_d  = rd_done && last ? rd_data_in : data_out_q;
    out_valid_d = fsm_d == ST_DONE;
    err_d       = kill;
  end

  always_comb begin
    start_ready = fsm_q == ST_IDLE;
    key_req     = fsm_q == ST_KEY_REQ;
    key_idx     = key_req ? round_q : '0;
    rd_valid    = fsm_q == ST_ISSUE;
    rd_round    = rd_valid ? round_q : '0;
    rd_first    = rd_valid && round_q == '0;
    rd_final    = rd_valid && last;
    rd_data     = rd_valid ? state_q : '0;
    rd_key      = rd_valid ? key_q : '0;
    out_valid   = out_valid_q;
    data_out    = data_out_q;
    err         = err_q;
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: randomized self-checking bench for NR=10 and NR=14 controllers.
module tb_aes_round_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start_valid = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [127:0] data_in = '0;
  logic sr[2], kreq[2], rv[2], rfst[2], rfin[2], ov[2], er[2];
  logic [3:0] kidx[2], rr[2];
  logic [127:0] rdd[2], rkk[2], dout[2];
  logic kv[2] = '{1'b0, 1'b0}, rvi[2] = '{1'b0, 1'b0};
  logic [127:0] rk[2] = '{128'd0, 128'd0}, rdi[2] = '{128'd0, 128'd0};

  int checks = 0, failures = 0, cyc = 0, acc = 0;
  int ks_r = 99, ks_n = 0, rs_r = 99, rs_n = 0;
  int kleft[2], rleft[2], knext[2], kbad[2], rnext[2], rbad[2];
  bit hold_rd = 1'b0, pend[2];
  logic [127:0] pdat[2], cur_pt;
  logic [3:0] pround[2];

  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl #(.NR(10)) u_nr10 (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(sr[0]),
    .data_in(data_in), .abort(abort), .key_req(kreq[0]), .key_idx(kidx[0]),
    .key_valid_in(kv[0]), .round_key(rk[0]), .rd_valid(rv[0]), .rd_round(rr[0]),
    .rd_first(rfst[0]), .rd_final(rfin[0]), .rd_data(rdd[0]), .rd_key(rkk[0]),
    .rd_valid_in(rvi[0]), .rd_data_in(rdi[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .data_out(dout[0]), .err(er[0])
  );

  aes_round_ctrl #(.NR(14)) u_nr14 (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(sr[1]),
    .data_in(data_in), .abort(abort), .key_req(kreq[1]), .key_idx(kidx[1]),
    .key_valid_in(kv[1]), .round_key(rk[1]), .rd_valid(rv[1]), .rd_round(rr[1]),
    .rd_first(rfst[1]), .rd_final(rfin[1]), .rd_data(rdd[1]), .rd_key(rkk[1]),
    .rd_valid_in(rvi[1]), .rd_data_in(rdi[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .data_out(dout[1]), .err(er[1])
  );

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nr_of(int i);
    return i == 0 ? 10 : 14;
  endfunction

  function automatic logic [127:0] kf(int r);
    return {4{32'h9e3779b9 * 32'(r + 1)}};
  endfunction

  function automatic logic [127:0] rfn(logic [127:0] s, logic [127:0] k, int r);
    return ({s[94:0], s[127:95]} + k) ^ 128'(r * 5 + 1);
  endfunction

  function automatic logic [127:0] model(logic [127:0] pt, int n);
    logic [127:0] s = pt;
    for (int r = 0; r < n; r++) s = rfn(s, kf(r), r);
    return s;
  endfunction

  function automatic int exp_lat(int i);
    int nr = nr_of(i);
    return 3 * (nr + 1) + (ks_r <= nr ? ks_n : 0) + (rs_r <= nr ? rs_n : 0);
  endfunction

  // Zero-wait key store and one-cycle datapath stand-ins, with optional single stalls.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      kv[i] = 1'b0;
      if (kreq[i]) begin
        if (int'(kidx[i]) == ks_r && kleft[i] > 0) kleft[i]--;
        else begin
          kv[i] = 1'b1;
          rk[i] = kf(int'(kidx[i]));
          if (int'(kidx[i]) != knext[i]) kbad[i]++;
          knext[i]++;
        end
      end
      rvi[i] = 1'b0;
      if (pend[i] && !hold_rd) begin
        if (int'(pround[i]) == rs_r && rleft[i] > 0) rleft[i]--;
        else begin
          rvi[i] = 1'b1;
          rdi[i] = pdat[i];
          pend[i] = 1'b0;
        end
      end
      if (rv[i]) begin
        chk("rd_key", rkk[i], kf(int'(rr[i])));
        chk("rd_data", rdd[i], model(cur_pt, int'(rr[i])));
        chk("rd_first", 128'(rfst[i]), 128'(rr[i] == 4'd0));
        chk("rd_final", 128'(rfin[i]), 128'(int'(rr[i]) == nr_of(i)));
        if (int'(rr[i]) != rnext[i]) rbad[i]++;
        rnext[i]++;
        pend[i] = 1'b1;
        pdat[i] = rfn(rdd[i], rkk[i], int'(rr[i]));
        pround[i] = rr[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_start_ready"}, 128'(sr[i]), 128'd1);
      chk({tag, "_key_req"}, 128'(kreq[i]), 128'd0);
      chk({tag, "_key_idx"}, 128'(kidx[i]), 128'd0);
      chk({tag, "_rd_valid"}, 128'(rv[i]), 128'd0);
      chk({tag, "_rd_round"}, 128'(rr[i]), 128'd0);
      chk({tag, "_rd_first"}, 128'(rfst[i]), 128'd0);
      chk({tag, "_rd_final"}, 128'(rfin[i]), 128'd0);
      chk({tag, "_rd_data"}, rdd[i], 128'd0);
      chk({tag, "_rd_key"}, rkk[i], 128'd0);
      chk({tag, "_out_valid"}, 128'(ov[i]), 128'd0);
      chk({tag, "_data_out"}, dout[i], 128'd0);
      chk({tag, "_err"}, 128'(er[i]), 128'd0);
    end
  endtask

  task automatic start(logic [127:0] pt, int kr, int kn, int rsr, int rsn);
    ks_r = kr; ks_n = kn; rs_r = rsr; rs_n = rsn;
    for (int i = 0; i < 2; i++) begin
      kleft[i] = kn; rleft[i] = rsn;
      knext[i] = 0; kbad[i] = 0; rnext[i] = 0; rbad[i] = 0;
    end
    cur_pt = pt;
    data_in = pt;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    acc = cyc;
    for (int i = 0; i < 2; i++) chk("accept_busy", 128'(sr[i]), 128'd0);
  endtask

  task automatic finish(int bp, bit do_lat);
    bit seen[2], hs[2], done[2];
    int left = bp;
    out_ready = bp == 0;
    for (int t = 0; t < 400 && !(done[0] && done[1]); t++) begin
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) begin
          chk("ready_after_hs", 128'(sr[i]), 128'd1);
          chk("ov_drop", 128'(ov[i]), 128'd0);
          done[i] = 1'b1;
          hs[i] = 1'b0;
        end
        if (ov[i] && !seen[i]) begin
          seen[i] = 1'b1;
          if (do_lat) chk("latency", 128'(cyc - acc), 128'(exp_lat(i)));
          chk("data_out", dout[i], model(cur_pt, nr_of(i) + 1));
          chk("data_out_last", dout[i], rdi[i]);
          chk("err_quiet", 128'(er[i]), 128'd0);
          chk("key_count", 128'(knext[i]), 128'(nr_of(i) + 1));
          chk("key_order", 128'(kbad[i]), 128'd0);
          chk("round_count", 128'(rnext[i]), 128'(nr_of(i) + 1));
          chk("round_order", 128'(rbad[i]), 128'd0);
        end
      end
      if ((seen[0] || seen[1]) && left > 0) begin
        for (int i = 0; i < 2; i++)
          if (seen[i] && !done[i]) begin
            chk("bp_valid", 128'(ov[i]), 128'd1);
            chk("bp_data", dout[i], model(cur_pt, nr_of(i) + 1));
            chk("bp_busy", 128'(sr[i]), 128'd0);
          end
        start_valid = left == 3;
        data_in = ~cur_pt;
        left--;
      end else if (seen[0] || seen[1]) out_ready = 1'b1;
      for (int i = 0; i < 2; i++) hs[i] = ov[i] && out_ready && !done[i];
      tick();
    end
    chk("block_done", 128'(done[0] && done[1]), 128'd1);
    start_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic wait_round(int r);
    int t = 0;
    while (t < 300 && !(rv[0] && int'(rr[0]) == r)) begin
      tick();
      t++;
    end
    chk("reach_round", 128'(rv[0] && int'(rr[0]) == r), 128'd1);
  endtask

  initial begin
    bit e;
    int w;
    repeat (3) tick();
    chk_reset("reset");
    reset = 1'b0;
    tick();

    start(128'h00112233445566778899aabbccddeeff, 99, 0, 99, 0);
    finish(0, 1'b1);

    start({$urandom, $urandom, $urandom, $urandom}, 5, 3, 99, 0);
    finish(0, 1'b1);

    start({$urandom, $urandom, $urandom, $urandom}, 99, 0, 99, 0);
    finish(5, 1'b1);

    start({$urandom, $urandom, $urandom, $urandom}, 99, 0, 99, 0);
    wait_round(4);
    hold_rd = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("abort_err", 128'(er[i]), 128'd1);
      chk("abort_idle", 128'(sr[i]), 128'd1);
      chk("abort_no_out", 128'(ov[i]), 128'd0);
    end
    abort = 1'b0;
    hold_rd = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) chk("abort_err_once", 128'(er[i]), 128'd0);
    start({$urandom, $urandom, $urandom, $urandom}, 99, 0, 99, 0);
    finish(0, 1'b1);

    start({$urandom, $urandom, $urandom, $urandom}, 99, 0, 99, 0);
    wait_round(7);
    reset = 1'b1;
    tick();
    chk_reset("rst_mid");
    reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) chk("rst_mid_no_err", 128'(er[i]), 128'd0);
    start({$urandom, $urandom, $urandom, $urandom}, 99, 0, 99, 0);
    finish(0, 1'b1);

    for (int n = 0; n < 6; n++) begin
      start({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 14)),
            int'($urandom_range(0, 4)), int'($urandom_range(0, 14)), int'($urandom_range(0, 3)));
      finish(int'($urandom_range(0, 6)), 1'b1);
    end

    start({$urandom, $urandom, $urandom, $urandom}, 99, 0, 99, 0);
    wait_round(2);
    hold_rd = 1'b1;
    w = cyc + 1;
`ifdef AES_RND_CTRL_TIMEOUT_EN
    for (int t = 0; t < 100 && !er[0]; t++) tick();
    for (int i = 0; i < 2; i++) begin
      chk("tmo_err", 128'(er[i]), 128'd1);
      chk("tmo_idle", 128'(sr[i]), 128'd1);
    end
    chk("tmo_cycles", 128'(cyc - w), 128'd64);
    hold_rd = 1'b0;
    tick();
`else
    e = 1'b0;
    repeat (100) begin
      tick();
      e = e | er[0] | er[1] | ov[0] | ov[1] | sr[0] | sr[1];
    end
    chk("wait_forever", 128'(e), 128'd0);
    hold_rd = 1'b0;
    finish(0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES round sequencer for the encryption core. Accepts one 128-bit block per start handshake, fetches round keys 0..NR from key storage, and issues each round to the round datapath (SubBytes/ShiftRows/MixColumns followed by AddRoundKey). It captures each round result and presents the final ciphertext on a valid/ready output. It sits between the top-level block interface, the key-expansion storage and the round datapath.

## Interface
- DATA_W, 128, block/key width
- NR, 10, number of rounds; legal values 10, 12, 14
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the macro)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_valid  in  1  new block available
- start_ready  out  1  controller idle; the block is accepted when start_valid & start_ready
- data_in  in  DATA_W  plaintext
- abort  in  1  synchronous abort request
- key_req  out  1  round-key request, held until granted
- key_idx  out  4  requested round index
- key_valid_in  in  1  round_key valid for key_idx
- round_key  in  DATA_W  round key
- rd_valid  out  1  one-cycle issue strobe to the datapath
- rd_round  out  4  round index of the issued round
- rd_first  out  1  round 0: datapath performs AddRoundKey only
- rd_final  out  1  round NR: datapath skips MixColumns
- rd_data  out  DATA_W  round input state
- rd_key  out  DATA_W  round key for the issued round
- rd_valid_in  in  1  datapath result valid
- rd_data_in  in  DATA_W  datapath result
- out_valid  out  1  ciphertext valid, held until accepted
- out_ready  in  1  downstream accepts the ciphertext
- data_out  out  DATA_W  ciphertext
- err  out  1  one-cycle pulse on abort or timeout

## Operation
- States are IDLE, KEY_REQ, ISSUE, WAIT and DONE.
- **IDLE:** start_ready=1. On an accepted start, capture data_in into state_q, set round_q=0 and go to KEY_REQ.
- **KEY_REQ:** key_req=1 and key_idx=round_q.
  - key_valid_in is sampled only in this state and may arrive in the first cycle.
  - On key_valid_in, latch round_key into key_q and go to ISSUE.
- **ISSUE:** rd_valid=1 for exactly one cycle. The round is presented as follows:
  - rd_data=state_q and rd_key=key_q.
  - rd_round=round_q.
  - rd_first=(round_q==0) and rd_final=(round_q==NR).
  - The controller then goes to WAIT.
- **WAIT:** on rd_valid_in, capture rd_data_in into state_q.
  - If round_q==NR, go to DONE.
  - Otherwise increment round_q and go to KEY_REQ.
  - rd_valid_in outside WAIT is ignored.
- **DONE:** out_valid=1 and data_out=state_q. On out_ready, go to IDLE.
- round_q is 4 bits and never exceeds NR; no wrap-around is possible.
- **abort:** abort has priority over every other event. In any non-IDLE state, the next state is IDLE, err pulses, and no out_valid is produced. abort in IDLE is ignored.
- **start while busy:** start_valid is ignored while start_ready=0.

## Timing
- **Reset values:** every output is 0, except start_ready=1. state_q, key_q and round_q are 0, and the state is IDLE. Reset mid-operation discards the block with no err pulse.
- With zero-wait key storage and a one-cycle datapath, each round takes 3 cycles (KEY_REQ, ISSUE, WAIT).
- out_valid rises 3*(NR+1) edges after the accepting edge: 33 edges for NR=10, 45 for NR=14.
- Each key stall or datapath stall cycle adds one cycle.
- Back-to-back blocks are supported: start_ready rises the cycle after the out_valid & out_ready edge.
- All outputs are registered, except key_req, key_idx, rd_* and start_ready, which are decoded from registered state only.

## Configuration
- **AES_RND_CTRL_TIMEOUT_EN defined:** a watchdog counter resets on every state change and counts cycles spent in KEY_REQ or WAIT. When it reaches TIMEOUT_CYC, the controller goes to IDLE and pulses err.
- **AES_RND_CTRL_TIMEOUT_EN not defined:** there is no counter, the controller waits indefinitely, and err pulses only on abort.

## Structure
- Shared package aes_pkg holds:
  - the state enum type;
  - AES_NR128/192/256 = 10/12/14;
  - ROUND_W=4;
  - AES_BLOCK_W=128.
- One sub-module, aes_rnd_watchdog: a counter with clear, enable and expire output, instantiated only under the macro.
- The datapath and key storage are external.

## Test plan
- **Basic NR=10:** data_in=00112233445566778899aabbccddeeff with zero-wait responders.
  - key_idx sequence is 0..10.
  - rd_first is high only for round 0 and rd_final only for round 10.
  - out_valid rises at edge 33 and data_out equals the last rd_data_in.
- **Key stall:** key_valid_in delayed 3 cycles at round 5 -> out_valid at edge 36; key_req stays high throughout the stall.
- **Backpressure:** out_ready low for 5 cycles in DONE -> out_valid and data_out hold, start_ready=0, and a start_valid pulse in that window is ignored.
- **Abort:** abort during WAIT of round 4 -> IDLE on the next edge and err pulses once. A new block is then accepted and completes normally.
- **Reset mid-block:** reset during round 7 -> all outputs return to reset values with no err pulse. NR=14 completes at edge 45.
- **Timeout (macro on):** rd_valid_in withheld -> err after TIMEOUT_CYC=64 cycles in WAIT, then IDLE. With the macro off, the controller stays in WAIT.
